// File: rtl/cache_controller_pkg.sv
// Shared types and field geometry for the 2-way, 64-set write-through cache controller.
// Address layout: offset = addr[2], index = addr[8:3], tag = addr[19:9].
package cache_controller_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int TAG_W      = 11;
  localparam int INDEX_W    = 6;
  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int BLOCK_W    = 64;
  localparam int OFFSET_POS = 2;
  localparam int INDEX_LSB  = 3;
  localparam int TAG_LSB    = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_MISS = 2'd1,
    ST_WRITE     = 2'd2
  } state_e;

  // Field order matches address[19:2] so a straight cast performs the split.
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               offset;
  } addr_fields_t;

  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] block,
                                                    input logic               offset);
    return offset ? block[BLOCK_W-1 -: WORD_W] : block[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// Set storage: per-way valid/tag/data plus one LRU bit per set.
// Combinational read at 'index'; fill, valid-clear and LRU update all take effect at the clock edge.
module cache_set_array
  import cache_controller_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INDEX_W-1:0]              index,
  output logic [WAYS-1:0]                 rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]      rd_tag,
  output logic [WAYS-1:0][BLOCK_W-1:0]    rd_data,
  output logic                            rd_lru,
  input  logic                            fill_en,
  input  logic                            fill_way,
  input  logic [TAG_W-1:0]                fill_tag,
  input  logic [BLOCK_W-1:0]              fill_data,
  input  logic                            inval_en,
  input  logic                            inval_way,
  input  logic                            lru_en,
  input  logic                            lru_val
);

  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0]           lru_q, lru_d;

  logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
  logic [BLOCK_W-1:0] data_mem [SETS][WAYS];

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    valid_d = valid_q;
    lru_d   = lru_q;
    if (fill_en) begin
      valid_d[index][fill_way] = 1'b1;
    end
    if (inval_en) begin
      valid_d[index][inval_way] = 1'b0;
    end
    if (lru_en) begin
      lru_d[index] = lru_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // NOTE: tag/data are a plain memory with no reset; valid bits alone decide whether contents matter.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index][fill_way]  <= fill_tag;
      data_mem[index][fill_way] <= fill_data;
    end
  end

  always_comb begin
    rd_lru = lru_q[index];
    for (int w = 0; w < WAYS; w++) begin
      rd_valid[w] = valid_q[index][w];
      rd_tag[w]   = tag_mem[index][w];
      rd_data[w]  = data_mem[index][w];
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through / no-write-allocate cache controller.
// Read hits complete combinationally in IDLE; misses and writes stall the pipeline until sram_ready.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [ADDR_W-1:0]   address,
  input  logic [WORD_W-1:0]   wdata,
  output logic [WORD_W-1:0]   rdata,
  output logic                ready,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [WORD_W-1:0]   sram_wdata,
  output logic                sram_r_en,
  output logic                sram_w_en,
  input  logic [BLOCK_W-1:0]  sram_rdata,
  input  logic                sram_ready
);

  state_e state_q, state_d;

  addr_fields_t req;
  assign req = addr_fields_t'(address[TAG_LSB+TAG_W-1:OFFSET_POS]);

  logic [WAYS-1:0]              rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]   rd_tag;
  logic [WAYS-1:0][BLOCK_W-1:0] rd_data;
  logic                         rd_lru;

  logic fill_en, inval_en, lru_en, lru_val;
  logic [WAYS-1:0] hit_vec;
  logic hit, hit_way, victim_way;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = rd_valid[w] && (rd_tag[w] == req.tag);
    end
  end

  assign hit     = |hit_vec;
  assign hit_way = ~hit_vec[0];

  // Empty ways are filled before any valid block is evicted; LRU only decides when both are live.
  assign victim_way = !rd_valid[0] ? 1'b0 :
                      !rd_valid[1] ? 1'b1 : rd_lru;

  assign sram_address = address;
  assign sram_wdata   = wdata;

  cache_set_array u_set_array (
    .clk       (clk),
    .rst       (rst),
    .index     (req.index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .rd_lru    (rd_lru),
    .fill_en   (fill_en),
    .fill_way  (victim_way),
    .fill_tag  (req.tag),
    .fill_data (sram_rdata),
    .inval_en  (inval_en),
    .inval_way (hit_way),
    .lru_en    (lru_en),
    .lru_val   (lru_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b1;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    fill_en   = 1'b0;
    inval_en  = 1'b0;
    lru_en    = 1'b0;
    lru_val   = 1'b0;

    // Under reset everything stays at the defaults: an in-flight fill or invalidate is dropped.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (MEM_W_EN) begin
            ready    = 1'b0;
            inval_en = hit;
            state_d  = ST_WRITE;
          end else if (MEM_R_EN) begin
            if (hit) begin
              rdata   = select_word(rd_data[hit_way], req.offset);
              lru_en  = 1'b1;
              lru_val = ~hit_way;
            end else begin
              ready   = 1'b0;
              state_d = ST_READ_MISS;
            end
          end
        end

        ST_READ_MISS: begin
          sram_r_en = 1'b1;
          ready     = 1'b0;
          if (sram_ready) begin
            ready   = 1'b1;
            rdata   = select_word(sram_rdata, req.offset);
            fill_en = 1'b1;
            lru_en  = 1'b1;
            lru_val = ~victim_way;
            state_d = ST_IDLE;
          end
        end

        ST_WRITE: begin
          sram_w_en = 1'b1;
          ready     = 1'b0;
          if (sram_ready) begin
            ready   = 1'b1;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: the bench plays the SRAM controller and predicts hits with a per-set
// recency list (MRU/LRU tag pair) and read data from a flat word-addressed memory model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_r_en, sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] mem [logic [17:0]];
  logic [10:0] m_mru [64];
  logic [10:0] m_lru [64];
  int          m_cnt [64];

  function automatic logic [31:0] mem_rd(input logic [17:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'(a[8:3]);
    return (m_cnt[s] >= 1 && m_mru[s] == a[19:9]) || (m_cnt[s] == 2 && m_lru[s] == a[19:9]);
  endfunction

  task automatic model_touch(input logic [31:0] a);
    int s = int'(a[8:3]);
    if (m_cnt[s] == 2 && m_lru[s] == a[19:9]) begin
      m_lru[s] = m_mru[s];
      m_mru[s] = a[19:9];
    end
  endtask

  task automatic model_fill(input logic [31:0] a);
    int s = int'(a[8:3]);
    m_lru[s] = m_mru[s];
    m_mru[s] = a[19:9];
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic model_inval(input logic [31:0] a);
    int s = int'(a[8:3]);
    if (m_cnt[s] >= 1 && m_mru[s] == a[19:9]) begin
      m_mru[s] = m_lru[s];
      m_cnt[s]--;
    end else if (m_cnt[s] == 2 && m_lru[s] == a[19:9]) begin
      m_cnt[s] = 1;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) m_cnt[s] = 0;
  endtask

  // ---------------- transactions ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output bit got_hit);
    bit          exp_hit;
    logic [31:0] exp_word;
    logic [17:0] wa;
    int          lat;
    wa = a[19:2];
    @(negedge clk);
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = a; wdata = $urandom;
    sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
    #1;
    exp_hit  = model_hit(a);
    exp_word = mem_rd(wa);
    got_hit  = ready;
    checks++;
    if ({ready, rdata, sram_r_en, sram_w_en} !== {exp_hit, (exp_hit ? exp_word : 32'h0), 2'b00}) begin
      errors++;
      $display("FAIL read_first addr=%h: ready=%b rdata=%h r_en=%b w_en=%b, want ready=%b rdata=%h r_en=0 w_en=0",
               a, ready, rdata, sram_r_en, sram_w_en, exp_hit, exp_hit ? exp_word : 32'h0);
    end
    @(posedge clk);
    if (exp_hit) begin
      model_touch(a);
    end else begin
      lat = $urandom_range(0, 2);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        sram_rdata = {$urandom, $urandom};
        #1;
        checks++;
        if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b0, 32'h0, 2'b10}) begin
          errors++;
          $display("FAIL read_wait addr=%h: ready=%b rdata=%h r_en=%b w_en=%b, want 0/0/1/0",
                   a, ready, rdata, sram_r_en, sram_w_en);
        end
      end
      @(negedge clk);
      sram_ready = 1'b1;
      sram_rdata = {mem_rd({wa[17:1], 1'b1}), mem_rd({wa[17:1], 1'b0})};
      #1;
      checks++;
      if ({ready, rdata, sram_r_en, sram_address} !== {1'b1, exp_word, 1'b1, a}) begin
        errors++;
        $display("FAIL read_fill addr=%h: ready=%b rdata=%h r_en=%b sram_addr=%h, want 1/%h/1/%h",
                 a, ready, rdata, sram_r_en, sram_address, exp_word, a);
      end
      @(posedge clk);
      model_fill(a);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
    int lat;
    @(negedge clk);
    MEM_W_EN = 1'b1; MEM_R_EN = both; address = a; wdata = d;
    sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
    #1;
    checks++;
    if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b0, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL write_first addr=%h: ready=%b rdata=%h r_en=%b w_en=%b, want 0/0/0/0",
               a, ready, rdata, sram_r_en, sram_w_en);
    end
    @(posedge clk);
    model_inval(a);
    lat = $urandom_range(0, 2);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b0, 32'h0, 2'b01}) begin
        errors++;
        $display("FAIL write_wait addr=%h: ready=%b rdata=%h r_en=%b w_en=%b, want 0/0/0/1",
                 a, ready, rdata, sram_r_en, sram_w_en);
      end
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    checks++;
    if ({ready, rdata, sram_r_en, sram_w_en, sram_address, sram_wdata} !== {1'b1, 32'h0, 2'b01, a, d}) begin
      errors++;
      $display("FAIL write_done addr=%h: ready=%b rdata=%h r_en=%b w_en=%b sram_addr=%h sram_wdata=%h, want 1/0/0/1/%h/%h",
               a, ready, rdata, sram_r_en, sram_w_en, sram_address, sram_wdata, a, d);
    end
    @(posedge clk);
    mem[a[19:2]] = d;
  endtask

  task automatic expect_hit(input string name, input bit got, input bit want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: hit=%b, want %b", name, got, want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = k[0]; address = $urandom;
      wdata = $urandom; sram_ready = 1'b1; sram_rdata = {$urandom, $urandom};
      #1;
      checks++;
      if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00}) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b rdata=%h r_en=%b w_en=%b, want 1/0/0/0",
                 ready, rdata, sram_r_en, sram_w_en);
      end
    end
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    #1;
    checks++;
    if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b rdata=%h r_en=%b w_en=%b, want 1/0/0/0",
               ready, rdata, sram_r_en, sram_w_en);
    end
  endtask

  task automatic test_basic_fill();
    bit h;
    do_reset();
    mem[18'd0] = 32'h1111_1111;
    mem[18'd1] = 32'h2222_2222;
    do_read(32'h0000_0000, h); expect_hit("basic_first_miss", h, 1'b0);
    do_read(32'h0000_0004, h); expect_hit("basic_offset1_hit", h, 1'b1);
  endtask

  task automatic test_lru();
    bit h;
    do_reset();
    do_read(32'h0000_0200, h); expect_hit("lru_fill_t1", h, 1'b0);
    do_read(32'h0000_0400, h); expect_hit("lru_fill_t2", h, 1'b0);
    do_read(32'h0000_0200, h); expect_hit("lru_rehit_t1", h, 1'b1);
    do_read(32'h0000_0600, h); expect_hit("lru_fill_t3", h, 1'b0);
    do_read(32'h0000_0204, h); expect_hit("lru_t1_kept", h, 1'b1);
    do_read(32'h0000_0400, h); expect_hit("lru_t2_evicted", h, 1'b0);
  endtask

  task automatic test_write_through();
    bit h;
    do_reset();
    do_read(32'h0000_0000, h);
    do_read(32'h0000_0000, h); expect_hit("wt_cached", h, 1'b1);
    do_write(32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h0000_0000, h); expect_hit("wt_invalidated", h, 1'b0);
    do_write(32'h0000_0008, 32'hCAFE_F00D, 1'b1);
  endtask

  task automatic test_reset_mid_miss();
    bit h;
    do_reset();
    @(negedge clk);
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = 32'h0000_1238; sram_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({ready, sram_r_en} !== 2'b01) begin
      errors++;
      $display("FAIL rmiss_pending: ready=%b r_en=%b, want 0/1", ready, sram_r_en);
    end
    @(negedge clk);
    rst = 1'b1;
    sram_rdata = {$urandom, $urandom};
    #1;
    checks++;
    if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL rst_in_miss: ready=%b rdata=%h r_en=%b w_en=%b, want 1/0/0/0",
               ready, rdata, sram_r_en, sram_w_en);
    end
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0; MEM_R_EN = 1'b0;
    #1;
    checks++;
    if ({ready, sram_r_en} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_abort: ready=%b r_en=%b, want 1/0", ready, sram_r_en);
    end
    do_read(32'h0000_1238, h); expect_hit("abort_no_fill", h, 1'b0);
  endtask

  task automatic test_idle_sram_ready();
    bit h;
    do_reset();
    do_read(32'h0000_0A10, h);
    @(negedge clk);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = 32'h0000_0C10;
    sram_ready = 1'b1; sram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    checks++;
    if ({ready, rdata, sram_r_en, sram_w_en} !== {1'b1, 32'h0, 2'b00}) begin
      errors++;
      $display("FAIL idle_pulse: ready=%b rdata=%h r_en=%b w_en=%b, want 1/0/0/0",
               ready, rdata, sram_r_en, sram_w_en);
    end
    @(posedge clk);
    do_read(32'h0000_0A14, h); expect_hit("idle_pulse_keeps", h, 1'b1);
    do_read(32'h0000_0C10, h); expect_hit("idle_pulse_no_fill", h, 1'b0);
  endtask

  task automatic test_random();
    bit          h;
    logic [31:0] a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a = {12'($urandom), 11'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           1'($urandom), 2'($urandom)};
      if ($urandom_range(0, 9) < 7) begin
        do_read(a, h);
      end else begin
        do_write(a, $urandom, ($urandom_range(0, 3) == 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic_fill();
    test_lru();
    test_write_through();
    test_reset_mid_miss();
    test_idle_sram_ready();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
